// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the DRAM port arbiter: FSM states, transaction owner and the
// byte-enable decode applied to masks coming from lsu_operator.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IFETCH = 1'b0,
        OWN_DATA   = 1'b1
    } arb_owner_e;

    // lsu_operator emits an all-zero mask for full-word accesses.
    function automatic logic [3:0] lsu_be_decode(input logic [3:0] be);
        logic [3:0] dec;
        if (be == 4'h0) begin
            dec = 4'hF;
        end else begin
            dec = be;
        end
        return dec;
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter of instruction fetch and load/store onto one DRAM port.
// Optional ARB_PERF_CNT_EN adds saturating conflict and busy-stall counters.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              mem_en,
    input  logic              i_req_ip,
    input  logic [ADDR_W-1:0] i_addr_ip,
    input  logic              i_kill_ip,
    output logic              i_gnt_op,
    output logic              i_rvalid_op,
    output logic [DATA_W-1:0] i_rdata_op,
    input  logic              d_req_ip,
    input  logic              d_we_ip,
    input  logic [ADDR_W-1:0] d_addr_ip,
    input  logic [3:0]        d_be_ip,
    input  logic [DATA_W-1:0] d_wdata_ip,
    output logic              d_gnt_op,
    output logic              d_rvalid_op,
    output logic [DATA_W-1:0] d_rdata_op,
    output logic              mem_req_op,
    output logic              mem_we_op,
    output logic [ADDR_W-1:0] mem_addr_op,
    output logic [3:0]        mem_be_op,
    output logic [DATA_W-1:0] mem_wdata_op,
    input  logic              mem_ready_ip,
    input  logic              mem_rvalid_ip,
    input  logic [DATA_W-1:0] mem_rdata_ip
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]       perf_conflict_cnt_op,
    output logic [31:0]       perf_busy_stall_cnt_op
`endif
);

    localparam int STREAK_W = $clog2(STARVE_LIMIT + 1);

    arb_state_e          state_q, state_d;
    arb_owner_e          owner_q, owner_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [3:0]          be_q, be_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                kill_q, kill_d;
    logic                i_rvalid_q, i_rvalid_d;
    logic                d_rvalid_q, d_rvalid_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic grant_ok_s, fetch_ok_s, starved_s, i_gnt_s, d_gnt_s, fetch_kill_s, issue_s;

    // Winner selection; grants are combinational and suppressed while reset is held.
    always_comb begin
        grant_ok_s   = !reset && mem_en && (state_q == ARB_IDLE);
        fetch_ok_s   = i_req_ip && !i_kill_ip;
        starved_s    = i_req_ip && (streak_q == STREAK_W'(STARVE_LIMIT));
        fetch_kill_s = (owner_q == OWN_IFETCH) && i_kill_ip;
        if (grant_ok_s && fetch_ok_s && (!d_req_ip || starved_s)) begin
            i_gnt_s = 1'b1;
            d_gnt_s = 1'b0;
        end else if (grant_ok_s && d_req_ip) begin
            i_gnt_s = 1'b0;
            d_gnt_s = 1'b1;
        end else begin
            i_gnt_s = 1'b0;
            d_gnt_s = 1'b0;
        end
    end

    // Transaction sequencing, request latching and response capture.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        streak_d   = streak_q;
        kill_d     = kill_q;
        rdata_d    = rdata_q;
        i_rvalid_d = 1'b0;
        d_rvalid_d = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                kill_d = 1'b0;
                if (i_gnt_s) begin
                    owner_d  = OWN_IFETCH;
                    we_d     = 1'b0;
                    addr_d   = i_addr_ip;
                    be_d     = 4'hF;
                    wdata_d  = {DATA_W{1'b0}};
                    streak_d = {STREAK_W{1'b0}};
                    state_d  = ARB_ISSUE;
                end else if (d_gnt_s) begin
                    owner_d = OWN_DATA;
                    we_d    = d_we_ip;
                    addr_d  = d_addr_ip;
                    be_d    = lsu_be_decode(d_be_ip);
                    wdata_d = d_wdata_ip;
                    state_d = ARB_ISSUE;
                    // Only a fetch that was actually passed over counts toward starvation.
                    if (!i_req_ip) begin
                        streak_d = {STREAK_W{1'b0}};
                    end else if (streak_q != STREAK_W'(STARVE_LIMIT)) begin
                        streak_d = streak_q + STREAK_W'(1);
                    end else begin
                        streak_d = streak_q;
                    end
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_ISSUE: begin
                kill_d = kill_q | fetch_kill_s;
                if (mem_ready_ip) begin
                    state_d = ARB_WAIT;
                end else begin
                    state_d = ARB_ISSUE;
                end
            end
            ARB_WAIT: begin
                kill_d = kill_q | fetch_kill_s;
                if (mem_rvalid_ip) begin
                    rdata_d    = mem_rdata_ip;
                    i_rvalid_d = (owner_q == OWN_IFETCH) && !(kill_q || fetch_kill_s);
                    d_rvalid_d = (owner_q == OWN_DATA);
                    state_d    = ARB_IDLE;
                end else begin
                    state_d = ARB_WAIT;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // State and holding registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ARB_IDLE;
            owner_q    <= OWN_IFETCH;
            we_q       <= 1'b0;
            addr_q     <= {ADDR_W{1'b0}};
            be_q       <= 4'h0;
            wdata_q    <= {DATA_W{1'b0}};
            streak_q   <= {STREAK_W{1'b0}};
            kill_q     <= 1'b0;
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            rdata_q    <= {DATA_W{1'b0}};
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            streak_q   <= streak_d;
            kill_q     <= kill_d;
            i_rvalid_q <= i_rvalid_d;
            d_rvalid_q <= d_rvalid_d;
            rdata_q    <= rdata_d;
        end
    end

    assign issue_s      = (state_q == ARB_ISSUE);
    assign i_gnt_op     = i_gnt_s;
    assign d_gnt_op     = d_gnt_s;
    assign i_rvalid_op  = i_rvalid_q;
    assign d_rvalid_op  = d_rvalid_q;
    assign i_rdata_op   = rdata_q;
    assign d_rdata_op   = rdata_q;
    assign mem_req_op   = issue_s;
    assign mem_we_op    = issue_s & we_q;
    assign mem_addr_op  = issue_s ? addr_q : {ADDR_W{1'b0}};
    assign mem_be_op    = issue_s ? be_q : 4'h0;
    assign mem_wdata_op = issue_s ? wdata_q : {DATA_W{1'b0}};

`ifdef ARB_PERF_CNT_EN
    logic [31:0] conflict_q, busy_stall_q;

    // Saturating event counters.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            conflict_q   <= 32'd0;
            busy_stall_q <= 32'd0;
        end else begin
            if ((state_q == ARB_IDLE) && i_req_ip && d_req_ip && mem_en &&
                (conflict_q != 32'hFFFF_FFFF)) begin
                conflict_q <= conflict_q + 32'd1;
            end else begin
                conflict_q <= conflict_q;
            end
            if ((state_q != ARB_IDLE) && (i_req_ip || d_req_ip) &&
                (busy_stall_q != 32'hFFFF_FFFF)) begin
                busy_stall_q <= busy_stall_q + 32'd1;
            end else begin
                busy_stall_q <= busy_stall_q;
            end
        end
    end

    assign perf_conflict_cnt_op   = conflict_q;
    assign perf_busy_stall_cnt_op = busy_stall_q;
`endif

endmodule
